wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter placed upstream of the peripheral crossbar.
- Lets the NEORV32 xbus (master 0) and a DMA/streaming engine (master 1) share the 0xFFD0_0000 peripheral window.
- Uses round-robin grant. A grant is held for the whole CYC. An optional watchdog aborts transfers that never receive an ACK.
- Slave side feeds the crossbar directly. The crossbar requires idle STB/CYC to be 0.

Parameters:
- TIMEOUT_CYCLES, 256: cycles STB may stay high without ACK before abort (watchdog builds only); legal range 2..65535.
- CNT_W, 16: watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wb_m0_adr  in  32  master 0 address
- wb_m0_dat_o  in  32  master 0 write data
- wb_m0_dat_i  out  32  master 0 read data
- wb_m0_we  in  1  master 0 write enable
- wb_m0_sel  in  4  master 0 byte select
- wb_m0_stb  in  1  master 0 strobe
- wb_m0_cyc  in  1  master 0 cycle
- wb_m0_ack  out  1  master 0 acknowledge
- wb_m0_err  out  1  master 0 bus error (watchdog)
- wb_m1_*  same set and widths as wb_m0_*  master 1
- wb_s_adr  out  32  slave address
- wb_s_dat_o  out  32  slave write data
- wb_s_dat_i  in  32  slave read data
- wb_s_we  out  1  slave write enable
- wb_s_sel  out  4  slave byte select
- wb_s_stb  out  1  slave strobe
- wb_s_cyc  out  1  slave cycle
- wb_s_ack  in  1  slave acknowledge
- grant  out  2  one-hot current grant (bit0 = m0, bit1 = m1), for debug/status

Behaviour:
- FSM states: IDLE, GNT0, GNT1, ABORT. State is registered; datapath muxing is combinational from state.
- Reset (rst=1 at a clk edge):
  - state = IDLE; last-served pointer = 1, so m0 wins the first tie; watchdog counter = 0.
  - Every output is 0.
  - Reset mid-transfer drops wb_s_stb/cyc on the next cycle. No ACK/ERR is forwarded afterwards.
- IDLE:
  - All wb_s_* outputs are 0. Both masters see ack=0, err=0, dat_i=0.
  - Only m0_cyc high: go to GNT0. Only m1_cyc high: go to GNT1.
  - Both high: grant the master that is not the last-served one.
  - Arbitration latency: 1 cycle. The slave sees STB/CYC the cycle after the master raises CYC.
- GNTx:
  - wb_s_adr/dat_o/we/sel/stb/cyc equal master x's inputs combinationally.
  - wb_mx_ack = wb_s_ack and wb_mx_dat_i = wb_s_dat_i.
  - The other master sees ack=0, err=0, dat_i=0, regardless of its requests.
  - Grant persists while mx_cyc=1, covering multiple STB/ACK beats.
  - When mx_cyc=0: last-served = x, next state IDLE. IDLE costs at least one cycle between grants; no back-to-back handover.
- grant output: GNT0 gives 2'b01; GNT1 gives 2'b10; IDLE and ABORT give 2'b00.
- An ACK arriving while no grant is active is ignored.
- ERR: wb_mx_err is only ever driven by the watchdog. It is 0 in builds without WB_ARB_TIMEOUT_EN.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With WB_ARB_TIMEOUT_EN, counter operation:
  - In GNTx the counter increments each cycle with stb=1 and wb_s_ack=0.
  - It clears on wb_s_ack, on any state change, and when stb=0.
- With WB_ARB_TIMEOUT_EN, abort sequence:
  - When the counter equals TIMEOUT_CYCLES-1 and ack is still 0, assert wb_mx_err for exactly that cycle, with wb_mx_ack=0, then go to ABORT.
  - In ABORT: wb_s_stb = wb_s_cyc = 0, and the aborted master sees ack=0, err=0.
  - Leave ABORT for IDLE when the aborted master drops CYC; last-served = aborted master.
- Without WB_ARB_TIMEOUT_EN:
  - No counter and no ABORT state; err outputs are tied to 0.
  - A hung slave holds the grant indefinitely.

Test Plan:
- m0 single read to 0xFFD1_0004, slave ACKs with 0xDEADBEEF 2 cycles after STB -> wb_s_stb rises 1 cycle after m0_cyc; m0_dat_i=0xDEADBEEF with m0_ack; m1 outputs stay 0.
- m0 and m1 raise CYC in the same cycle after reset -> m0 granted first (grant=01); after m0 drops CYC, 1 IDLE cycle, then grant=10. Repeat the tie -> m0 again, showing alternation.
- m1 holds CYC for 4 STB/ACK beats while m0 requests -> grant stays 10 through all 4 beats; m0_ack never asserts; m0 is granted 2 cycles after m1 drops CYC.
- WB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, slave never ACKs m0 -> m0_err high for exactly 1 cycle, 8 cycles after STB; wb_s_cyc=0 next cycle; grant=00 until m0 drops CYC.
- rst pulsed during a GNT1 write, then the slave ACKs -> all outputs 0 the cycle after rst; the late ACK is not seen on m1_ack; next tie goes to m0.
- Macro undefined, slave stalls 1000 cycles -> no err, grant held, ACK forwarded when the slave finally responds.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Round-robin two-master to one-slave Wishbone arbiter. The grant
//            is held for the whole CYC. Define WB_ARB_TIMEOUT_EN to build the
//            no-ACK watchdog that aborts a stalled transfer.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_m0_adr,
    input  logic [31:0] wb_m0_dat_o,
    output logic [31:0] wb_m0_dat_i,
    input  logic        wb_m0_we,
    input  logic [3:0]  wb_m0_sel,
    input  logic        wb_m0_stb,
    input  logic        wb_m0_cyc,
    output logic        wb_m0_ack,
    output logic        wb_m0_err,
    input  logic [31:0] wb_m1_adr,
    input  logic [31:0] wb_m1_dat_o,
    output logic [31:0] wb_m1_dat_i,
    input  logic        wb_m1_we,
    input  logic [3:0]  wb_m1_sel,
    input  logic        wb_m1_stb,
    input  logic        wb_m1_cyc,
    output logic        wb_m1_ack,
    output logic        wb_m1_err,
    output logic [31:0] wb_s_adr,
    output logic [31:0] wb_s_dat_o,
    input  logic [31:0] wb_s_dat_i,
    output logic        wb_s_we,
    output logic [3:0]  wb_s_sel,
    output logic        wb_s_stb,
    output logic        wb_s_cyc,
    input  logic        wb_s_ack,
    output logic [1:0]  grant
);

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, ABORT = 2'd3} state_t;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > CNT_W);
`endif

    state_t state_q, state_d;
    // Index of the master served most recently; also names the aborted master.
    logic   last_q, last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant       = 2'b00;
        wb_s_adr    = '0;
        wb_s_dat_o  = '0;
        wb_s_we     = 1'b0;
        wb_s_sel    = '0;
        wb_s_stb    = 1'b0;
        wb_s_cyc    = 1'b0;
        wb_m0_dat_i = '0;
        wb_m0_ack   = 1'b0;
        wb_m0_err   = 1'b0;
        wb_m1_dat_i = '0;
        wb_m1_ack   = 1'b0;
        wb_m1_err   = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
        case (state_q)
            IDLE: begin
                if (wb_m0_cyc && wb_m1_cyc) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (wb_m0_cyc) begin
                    state_d = GNT0;
                end else if (wb_m1_cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                grant       = 2'b01;
                wb_s_adr    = wb_m0_adr;
                wb_s_dat_o  = wb_m0_dat_o;
                wb_s_we     = wb_m0_we;
                wb_s_sel    = wb_m0_sel;
                wb_s_stb    = wb_m0_stb;
                wb_s_cyc    = wb_m0_cyc;
                wb_m0_ack   = wb_s_ack;
                wb_m0_dat_i = wb_s_dat_i;
                if (!wb_m0_cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (wb_m0_stb && !wb_s_ack) begin
                    if (cnt_q == TO_LAST) begin
                        wb_m0_err = 1'b1;
                        wb_m0_ack = 1'b0;
                        state_d   = ABORT;
                        last_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
            end
            GNT1: begin
                grant       = 2'b10;
                wb_s_adr    = wb_m1_adr;
                wb_s_dat_o  = wb_m1_dat_o;
                wb_s_we     = wb_m1_we;
                wb_s_sel    = wb_m1_sel;
                wb_s_stb    = wb_m1_stb;
                wb_s_cyc    = wb_m1_cyc;
                wb_m1_ack   = wb_s_ack;
                wb_m1_dat_i = wb_s_dat_i;
                if (!wb_m1_cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (wb_m1_stb && !wb_s_ack) begin
                    if (cnt_q == TO_LAST) begin
                        wb_m1_err = 1'b1;
                        wb_m1_ack = 1'b0;
                        state_d   = ABORT;
                        last_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                if (last_q ? !wb_m1_cyc : !wb_m0_cyc) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed self-checking bench for wb_arbiter (TIMEOUT_CYCLES=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_m0_adr = '0, wb_m0_dat_o = '0, wb_m1_adr = '0, wb_m1_dat_o = '0;
    logic [31:0] wb_m0_dat_i, wb_m1_dat_i, wb_s_adr, wb_s_dat_o;
    logic [31:0] wb_s_dat_i = '0;
    logic        wb_m0_we = 1'b0, wb_m0_stb = 1'b0, wb_m0_cyc = 1'b0;
    logic        wb_m1_we = 1'b0, wb_m1_stb = 1'b0, wb_m1_cyc = 1'b0;
    logic [3:0]  wb_m0_sel = '0, wb_m1_sel = '0, wb_s_sel;
    logic        wb_m0_ack, wb_m0_err, wb_m1_ack, wb_m1_err;
    logic        wb_s_we, wb_s_stb, wb_s_cyc;
    logic        wb_s_ack = 1'b0;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .wb_m0_adr(wb_m0_adr), .wb_m0_dat_o(wb_m0_dat_o), .wb_m0_dat_i(wb_m0_dat_i),
        .wb_m0_we(wb_m0_we), .wb_m0_sel(wb_m0_sel), .wb_m0_stb(wb_m0_stb),
        .wb_m0_cyc(wb_m0_cyc), .wb_m0_ack(wb_m0_ack), .wb_m0_err(wb_m0_err),
        .wb_m1_adr(wb_m1_adr), .wb_m1_dat_o(wb_m1_dat_o), .wb_m1_dat_i(wb_m1_dat_i),
        .wb_m1_we(wb_m1_we), .wb_m1_sel(wb_m1_sel), .wb_m1_stb(wb_m1_stb),
        .wb_m1_cyc(wb_m1_cyc), .wb_m1_ack(wb_m1_ack), .wb_m1_err(wb_m1_err),
        .wb_s_adr(wb_s_adr), .wb_s_dat_o(wb_s_dat_o), .wb_s_dat_i(wb_s_dat_i),
        .wb_s_we(wb_s_we), .wb_s_sel(wb_s_sel), .wb_s_stb(wb_s_stb),
        .wb_s_cyc(wb_s_cyc), .wb_s_ack(wb_s_ack), .grant(grant)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and let outputs settle before any sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"}, {30'd0, grant}, 32'd0);
        check_eq({tag, "_s_ctl"}, {27'd0, wb_s_stb, wb_s_cyc, wb_s_we, wb_m0_ack, wb_m1_ack}, 32'd0);
        check_eq({tag, "_s_adr"}, wb_s_adr | wb_s_dat_o | {28'd0, wb_s_sel}, 32'd0);
        check_eq({tag, "_m_dat"}, wb_m0_dat_i | wb_m1_dat_i, 32'd0);
        check_eq({tag, "_err"}, {30'd0, wb_m0_err, wb_m1_err}, 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_all_zero("reset");

        // m0 single read, slave ACKs two cycles after STB
        wb_m0_adr = 32'hFFD1_0004; wb_m0_sel = 4'hF; wb_m0_cyc = 1'b1; wb_m0_stb = 1'b1;
        #1;
        check_eq("rd_latency_stb", {31'd0, wb_s_stb}, 32'd0);
        tick();
        check_eq("rd_grant", {30'd0, grant}, 32'd1);
        check_eq("rd_s_stb", {30'd0, wb_s_stb, wb_s_cyc}, 32'd3);
        check_eq("rd_s_adr", wb_s_adr, 32'hFFD1_0004);
        check_eq("rd_s_sel", {28'd0, wb_s_sel}, 32'hF);
        tick();
        tick();
        wb_s_ack = 1'b1; wb_s_dat_i = 32'hDEAD_BEEF;
        #1;
        check_eq("rd_m0_ack", {31'd0, wb_m0_ack}, 32'd1);
        check_eq("rd_m0_dat", wb_m0_dat_i, 32'hDEAD_BEEF);
        check_eq("rd_m1_quiet", {31'd0, wb_m1_ack} | wb_m1_dat_i, 32'd0);
        tick();
        wb_s_ack = 1'b0; wb_m0_cyc = 1'b0; wb_m0_stb = 1'b0;
        tick();
        check_eq("rd_idle_grant", {30'd0, grant}, 32'd0);
        check_eq("rd_idle_cyc", {31'd0, wb_s_cyc}, 32'd0);

        // Tie after reset: m0 first, then m1, then m0 again
        do_reset();
        wb_m0_cyc = 1'b1; wb_m1_cyc = 1'b1;
        tick();
        check_eq("tie1_grant", {30'd0, grant}, 32'd1);
        wb_m0_cyc = 1'b0;
        tick();
        check_eq("tie1_gap", {30'd0, grant}, 32'd0);
        tick();
        check_eq("tie1_m1", {30'd0, grant}, 32'd2);
        wb_m1_cyc = 1'b0;
        tick();
        wb_m0_cyc = 1'b1; wb_m1_cyc = 1'b1;
        tick();
        check_eq("tie2_grant", {30'd0, grant}, 32'd1);
        wb_m0_cyc = 1'b0; wb_m1_cyc = 1'b0;
        tick();

        // m1 holds four beats while m0 is waiting
        wb_m1_cyc = 1'b1; wb_m1_stb = 1'b1;
        tick();
        wb_m0_cyc = 1'b1; wb_m0_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_s_ack = 1'b1; wb_s_dat_i = 32'h1000_0000 + i;
            #1;
            check_eq($sformatf("burst_grant%0d", i), {30'd0, grant}, 32'd2);
            check_eq($sformatf("burst_m1_dat%0d", i), wb_m1_dat_i, 32'h1000_0000 + i);
            check_eq($sformatf("burst_m0_ack%0d", i), {31'd0, wb_m0_ack}, 32'd0);
            tick();
        end
        wb_s_ack = 1'b0; wb_m1_cyc = 1'b0; wb_m1_stb = 1'b0;
        tick();
        check_eq("burst_gap", {30'd0, grant}, 32'd0);
        tick();
        check_eq("burst_m0_grant", {30'd0, grant}, 32'd1);
        wb_m0_cyc = 1'b0; wb_m0_stb = 1'b0;
        tick();

        // Reset during an m1 write; late ACK must not reach m1
        wb_m1_cyc = 1'b1; wb_m1_stb = 1'b1; wb_m1_we = 1'b1;
        wb_m1_adr = 32'hFFD0_0010; wb_m1_dat_o = 32'hCAFE_F00D;
        tick();
        check_eq("wr_s_we", {31'd0, wb_s_we}, 32'd1);
        check_eq("wr_s_dat", wb_s_dat_o, 32'hCAFE_F00D);
        rst = 1'b1;
        tick();
        rst = 1'b0; wb_m1_cyc = 1'b0; wb_m1_stb = 1'b0; wb_m1_we = 1'b0;
        check_all_zero("rst_mid");
        wb_s_ack = 1'b1;
        #1;
        check_eq("rst_late_ack", {31'd0, wb_m1_ack}, 32'd0);
        tick();
        wb_s_ack = 1'b0;
        wb_m0_cyc = 1'b1; wb_m1_cyc = 1'b1;
        tick();
        check_eq("rst_tie_m0", {30'd0, grant}, 32'd1);
        wb_m0_cyc = 1'b0; wb_m1_cyc = 1'b0;
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: slave never ACKs m0
        do_reset();
        wb_m0_cyc = 1'b1; wb_m0_stb = 1'b1;
        begin
            int early = 0;
            for (int k = 1; k < 8; k++) begin
                tick();
                if (wb_m0_err !== 1'b0) early++;
            end
            check_eq("wd_no_early_err", early, 0);
        end
        tick();
        check_eq("wd_err", {31'd0, wb_m0_err}, 32'd1);
        check_eq("wd_err_ack", {31'd0, wb_m0_ack}, 32'd0);
        tick();
        check_eq("wd_err_once", {31'd0, wb_m0_err}, 32'd0);
        check_eq("wd_s_cyc", {30'd0, wb_s_cyc, wb_s_stb}, 32'd0);
        check_eq("wd_grant", {30'd0, grant}, 32'd0);
        tick();
        tick();
        check_eq("wd_hold_grant", {30'd0, grant}, 32'd0);
        wb_m0_cyc = 1'b0; wb_m0_stb = 1'b0;
        tick();
        wb_m0_cyc = 1'b1; wb_m1_cyc = 1'b1;
        tick();
        check_eq("wd_tie_m1", {30'd0, grant}, 32'd2);
        wb_m0_cyc = 1'b0; wb_m1_cyc = 1'b0;
        tick();
`else
        // Stalled slave without watchdog: grant held, no error
        wb_m0_cyc = 1'b1; wb_m0_stb = 1'b1;
        tick();
        begin
            int bad = 0;
            for (int k = 0; k < 1000; k++) begin
                if (wb_m0_err !== 1'b0 || grant !== 2'b01 || wb_m0_ack !== 1'b0) bad++;
                tick();
            end
            check_eq("stall_hold", bad, 0);
        end
        wb_s_ack = 1'b1; wb_s_dat_i = 32'h1234_5678;
        #1;
        check_eq("stall_ack", {31'd0, wb_m0_ack}, 32'd1);
        check_eq("stall_dat", wb_m0_dat_i, 32'h1234_5678);
        tick();
        wb_s_ack = 1'b0; wb_m0_cyc = 1'b0; wb_m0_stb = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
